// File: rtl/fetch_queue.sv
// Instruction queue between fetch and the parallel format decoders: a small circular
// buffer of {instruction, address} with a registered instruction/enable output stage.
module fetch_queue #(
  parameter int instructionWidth = 32,
  parameter int addressWidth     = 64,
  parameter int depthLog2        = 2
) (
  input  logic                          clock_i,
  input  logic                          reset_n_i,
  input  logic                          fetchValid_i,
  input  logic [0:instructionWidth-1]   instruction_i,
  input  logic [addressWidth-1:0]       address_i,
  output logic                          fetchReady_o,
  input  logic                          decodeStall_i,
  input  logic                          flush_i,
  output logic [0:instructionWidth-1]   instruction_o,
  output logic [addressWidth-1:0]       address_o,
  output logic                          enable_o,
  output logic [depthLog2:0]            count_o
);

  localparam int DEPTH = 2 ** depthLog2;
  localparam logic [depthLog2:0]   CNT_FULL = (depthLog2 + 1)'(DEPTH);
  localparam logic [depthLog2:0]   CNT_ONE  = (depthLog2 + 1)'(1);
  localparam logic [depthLog2-1:0] PTR_ONE  = depthLog2'(1);

  logic [0:instructionWidth-1] ins_mem_q [DEPTH];
  logic [addressWidth-1:0]     adr_mem_q [DEPTH];

  logic [depthLog2-1:0]        wptr_q, wptr_d;
  logic [depthLog2-1:0]        rptr_q, rptr_d;
  logic [depthLog2:0]          count_q, count_d;
  logic                        enable_q, enable_d;
  logic [0:instructionWidth-1] instr_q, instr_d;
  logic [addressWidth-1:0]     addr_q, addr_d;
  logic                        push, pop;

  // Ready depends only on the registered count, never on an input.
  assign fetchReady_o  = (count_q != CNT_FULL);
  assign instruction_o = instr_q;
  assign address_o     = addr_q;
  assign enable_o      = enable_q;
  assign count_o       = count_q;

  always_comb begin
    push     = fetchValid_i & fetchReady_o & ~flush_i;
    pop      = (count_q != '0) & ~decodeStall_i & ~flush_i;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    enable_d = 1'b0;
    instr_d  = instr_q;
    addr_d   = addr_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PTR_ONE;
      if (pop) begin
        rptr_d   = rptr_q + PTR_ONE;
        enable_d = 1'b1;
        instr_d  = ins_mem_q[rptr_q];
        addr_d   = adr_mem_q[rptr_q];
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked entirely by the pointers and count.
  always_ff @(posedge clock_i) begin
    if (push) begin
      ins_mem_q[wptr_q] <= instruction_i;
      adr_mem_q[wptr_q] <= address_i;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      enable_q <= 1'b0;
      instr_q  <= '0;
      addr_q   <= '0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      enable_q <= enable_d;
      instr_q  <= instr_d;
      addr_q   <= addr_d;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a scoreboard queue holds the entries the queue should
// contain, and every cycle the outputs are compared against it.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_valid;
  logic [0:31] instr_in;
  logic [63:0] addr_in;
  logic        ready;
  logic        stall;
  logic        flush;
  logic [0:31] instr_out;
  logic [63:0] addr_out;
  logic        enable;
  logic [2:0]  count;

  int checks   = 0;
  int failures = 0;
  int en_seen  = 0;

  logic [95:0] sb[$];
  logic [31:0] exp_ins;
  logic [63:0] exp_adr;

  always #5 clk = ~clk;

  fetch_queue #(.instructionWidth(32), .addressWidth(64), .depthLog2(2)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .fetchValid_i(fetch_valid), .instruction_i(instr_in),
    .address_i(addr_in), .fetchReady_o(ready), .decodeStall_i(stall), .flush_i(flush),
    .instruction_o(instr_out), .address_o(addr_out), .enable_o(enable), .count_o(count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, predict the edge from the scoreboard, compare #1 after it.
  task automatic step(input string tag, input logic v, input logic [31:0] ins,
                      input logic [63:0] a, input logic st, input logic fl);
    logic [95:0] e;
    logic        exp_en;
    bit          do_push, do_pop;
    fetch_valid = v;
    instr_in    = ins;
    addr_in     = a;
    stall       = st;
    flush       = fl;
    do_push = v && (sb.size() != 4) && !fl;
    do_pop  = (sb.size() != 0) && !st && !fl;
    @(posedge clk);
    exp_en = 1'b0;
    if (fl) sb.delete();
    else begin
      if (do_pop) begin
        e = sb.pop_front();
        exp_en  = 1'b1;
        exp_ins = e[95:64];
        exp_adr = e[63:0];
      end
      if (do_push) sb.push_back({ins, a});
    end
    #1;
    chk({tag, "_enable"}, 64'(enable), 64'(exp_en));
    chk({tag, "_instr"},  64'(instr_out), 64'(exp_ins));
    chk({tag, "_addr"},   addr_out, exp_adr);
    chk({tag, "_count"},  64'(count), 64'(sb.size()));
    chk({tag, "_ready"},  64'(ready), 64'(sb.size() != 4));
    if (enable === 1'b1) en_seen++;
    fetch_valid = 1'b0;
    flush       = 1'b0;
  endtask

  initial begin
    int base;
    rst_n = 1'b0; fetch_valid = 1'b0; instr_in = '0; addr_in = '0; stall = 1'b0; flush = 1'b0;
    exp_ins = '0; exp_adr = '0;
    #3;
    chk("rst_enable", 64'(enable), 64'd0);
    chk("rst_count",  64'(count), 64'd0);
    chk("rst_ready",  64'(ready), 64'd1);
    chk("rst_instr",  64'(instr_out), 64'd0);
    chk("rst_addr",   addr_out, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: single push, enable two edges later
    step("s1_push", 1'b1, 32'h3860_0005, 64'h100, 1'b0, 1'b0);
    step("s1_out",  1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    chk("s1_instr_const", 64'(instr_out), 64'h3860_0005);
    step("s1_idle", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    // 2: stall while pushing five; the fifth is dropped
    for (int i = 0; i < 5; i++)
      step("s2_fill", 1'b1, 32'hA000_0000 + 32'(i), 64'h1000 + 64'(4 * i), 1'b1, 1'b0);
    chk("s2_full_count", 64'(count), 64'd4);
    base = en_seen;
    for (int i = 0; i < 6; i++)
      step("s2_drain", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    chk("s2_out_count", 64'(en_seen - base), 64'd4);

    // 3: stream of ten with no stall, wraps the pointers
    base = en_seen;
    for (int i = 0; i < 10; i++)
      step("s3_stream", 1'b1, 32'h1000_0000 + 32'(i), 64'h200 + 64'(4 * i), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++)
      step("s3_tail", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    chk("s3_out_count", 64'(en_seen - base), 64'd10);

    // 4: three queued then flush with a concurrent push
    for (int i = 0; i < 3; i++)
      step("s4_fill", 1'b1, 32'hF000_0000 + 32'(i), 64'h300 + 64'(4 * i), 1'b1, 1'b0);
    step("s4_flush", 1'b1, 32'hF000_0003, 64'h30C, 1'b0, 1'b1);
    base = en_seen;
    for (int i = 0; i < 4; i++)
      step("s4_after", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    chk("s4_no_output", 64'(en_seen - base), 64'd0);

    // 5: asynchronous reset pulse between edges with two entries queued
    for (int i = 0; i < 2; i++)
      step("s5_fill", 1'b1, 32'hC000_0000 + 32'(i), 64'h400 + 64'(4 * i), 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_enable", 64'(enable), 64'd0);
    chk("s5_count",  64'(count), 64'd0);
    chk("s5_instr",  64'(instr_out), 64'd0);
    chk("s5_ready",  64'(ready), 64'd1);
    #1 rst_n = 1'b1;
    sb.delete();
    exp_ins = '0;
    exp_adr = '0;
    base = en_seen;
    for (int i = 0; i < 3; i++)
      step("s5_after", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);
    chk("s5_no_output", 64'(en_seen - base), 64'd0);

    // 6: simultaneous push and pop at count 2
    for (int i = 0; i < 2; i++)
      step("s6_fill", 1'b1, 32'h6000_0000 + 32'(i), 64'h500 + 64'(4 * i), 1'b1, 1'b0);
    step("s6_pushpop", 1'b1, 32'h6000_0002, 64'h508, 1'b0, 1'b0);
    chk("s6_count_held", 64'(count), 64'd2);
    for (int i = 0; i < 4; i++)
      step("s6_drain", 1'b0, 32'h0, 64'h0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
